// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and ALU operation codes.
// Imported by the control FSM, the immediate decoder, the ALU and the datapath.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH      = 4'b0000,
    ST_DECODE     = 4'b0001,
    ST_EXEC       = 4'b0101,
    ST_BRANCH     = 4'b0110,
    ST_MEM_RD     = 4'b0111,
    ST_MEM_WR     = 4'b1000,
    ST_WB_ALU     = 4'b1001,
    ST_WB_MEM     = 4'b1010,
    ST_BR_RESOLVE = 4'b1011,
    ST_HALT       = 4'b1111
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0110;
  localparam logic [3:0] ALU_BNE  = 4'b1111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from the instruction register: selects the I/S/B layout
// by opcode and returns the 12-bit magnitude plus the sign bit.
module imm_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [11:0] immediate,
  output logic        negativo
);

  logic [11:0] imm_raw;
  logic        unused_ir;

  // Bits 19:12 carry rs1/funct3 and never reach an immediate field.
  assign unused_ir = ^ir[19:12];

  always_comb begin
    unique case (ir[6:0])
      OP_STORE:  imm_raw = {ir[31:25], ir[11:7]};
      OP_BRANCH: imm_raw = {ir[31], ir[7], ir[30:25], ir[11:8]};
      default:   imm_raw = ir[31:20];
    endcase
  end

  // Two's-complement magnitude; -2048 maps to 12'h800, which is still correct read as unsigned.
  assign negativo  = imm_raw[11];
  assign immediate = negativo ? (~imm_raw + 12'd1) : imm_raw;

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: latches the instruction, decodes it and sequences FETCH..WB for the ALU.
// Define MEM_WAIT_EN to make FETCH/MEM_RD/MEM_WR wait for mem_ready; otherwise they last one cycle.
module control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned BRANCH_HOLD  = 2,
  parameter int unsigned ILLEGAL_HALT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        mem_ready,
  output logic [3:0]  estado,
  output logic        alusrc,
  output logic [3:0]  alucontrol,
  output logic [11:0] immediate,
  output logic        negativo,
  output logic        branch,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pc_branch,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        illegal
);

  localparam int CNT_W = (BRANCH_HOLD > 1) ? $clog2(BRANCH_HOLD) : 1;

  state_t             state, state_n;
  logic [31:0]        ir;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               run;
  logic               ir_load;
  logic               mem_ok;
  logic               valid, is_branch, is_load, is_store;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  imm_decode u_imm (
    .ir        (ir),
    .immediate (immediate),
    .negativo  (negativo)
  );

  always_comb begin
    valid      = 1'b1;
    is_branch  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    alusrc     = 1'b0;
    alucontrol = ALU_AND;
    unique case (ir[6:0])
      OP_R: begin
        unique case (ir[14:12])
          3'b000:  alucontrol = ir[30] ? ALU_SUB : ALU_ADD;
          3'b111:  alucontrol = ALU_AND;
          3'b110:  alucontrol = ALU_OR;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = ALU_SRL;
          default: valid = 1'b0;
        endcase
      end
      OP_IMM:    begin alusrc = 1'b1; alucontrol = ALU_ADDI; end
      OP_LOAD:   begin alusrc = 1'b1; alucontrol = ALU_ADD; is_load  = 1'b1; end
      OP_STORE:  begin alusrc = 1'b1; alucontrol = ALU_ADD; is_store = 1'b1; end
      OP_BRANCH: begin
        alusrc     = 1'b1;
        is_branch  = 1'b1;
        alucontrol = (ir[14:12] == 3'b001) ? ALU_BNE : ALU_BEQ;
      end
      default:   valid = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_FETCH;
      ir    <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      run   <= 1'b1;
      if (ir_load) ir <= instr;
    end
  end

  assign estado = state;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ir_load   = 1'b0;
    branch    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pc_branch = 1'b0;
    regwrite  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      // The first FETCH after reset is held idle until run is set, keeping strobes low in reset.
      ST_FETCH: if (run) begin
        memread = 1'b1;
        irwrite = 1'b1;
        if (mem_ok) begin
          ir_load = 1'b1;
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!valid) begin
          illegal = 1'b1;
          if (ILLEGAL_HALT != 0) begin
            state_n = ST_HALT;
          end else begin
            pcwrite = 1'b1;
            state_n = ST_FETCH;
          end
        end else if (is_branch) begin
          state_n = ST_BRANCH;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: state_n = is_load ? ST_MEM_RD : (is_store ? ST_MEM_WR : ST_WB_ALU);
      ST_MEM_RD: begin
        memread = 1'b1;
        if (mem_ok) state_n = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        memwrite = 1'b1;
        if (mem_ok) begin
          pcwrite = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        regwrite = (ir[11:7] != 5'd0);
        pcwrite  = 1'b1;
        state_n  = ST_FETCH;
      end
      ST_WB_MEM: begin
        regwrite = (ir[11:7] != 5'd0);
        memtoreg = 1'b1;
        pcwrite  = 1'b1;
        state_n  = ST_FETCH;
      end
      ST_BRANCH: begin
        branch = 1'b1;
        if (cnt == CNT_W'(BRANCH_HOLD - 1)) begin
          cnt_n   = '0;
          state_n = ST_BR_RESOLVE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_BR_RESOLVE: begin
        pc_branch = pcsrc;
        pcwrite   = 1'b1;
        state_n   = ST_FETCH;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: expected output words are queued as each step is driven and
// compared, one per clock, against the packed DUT outputs sampled 1 time unit after the edge.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        pcsrc;
  logic        mem_ready;
  logic [3:0]  estado;
  logic        alusrc;
  logic [3:0]  alucontrol;
  logic [11:0] immediate;
  logic        negativo;
  logic        branch, irwrite, pcwrite, pc_branch, regwrite;
  logic        memread, memwrite, memtoreg, illegal;

  control_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .pcsrc      (pcsrc),
    .mem_ready  (mem_ready),
    .estado     (estado),
    .alusrc     (alusrc),
    .alucontrol (alucontrol),
    .immediate  (immediate),
    .negativo   (negativo),
    .branch     (branch),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pc_branch  (pc_branch),
    .regwrite   (regwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Strobe bit order: branch irwrite pcwrite pc_branch regwrite memread memwrite memtoreg illegal
  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_BR   = 9'h100;
  localparam logic [8:0] S_IRW  = 9'h080;
  localparam logic [8:0] S_PCW  = 9'h040;
  localparam logic [8:0] S_PCB  = 9'h020;
  localparam logic [8:0] S_RW   = 9'h010;
  localparam logic [8:0] S_MR   = 9'h008;
  localparam logic [8:0] S_MW   = 9'h004;
  localparam logic [8:0] S_MTR  = 9'h002;
  localparam logic [8:0] S_ILL  = 9'h001;
  localparam logic [8:0] S_FETCH = S_IRW | S_MR;

  localparam logic [30:0] M_ALL   = '1;
  localparam logic [30:0] M_NOIMM = {4'hF, 1'b1, 4'hF, 12'h000, 1'b0, 9'h1FF};
  localparam logic [30:0] M_CTRL  = {4'hF, 1'b0, 4'h0, 12'h000, 1'b0, 9'h1FF};
  localparam logic [30:0] M_ILL   = {4'hF, 1'b0, 4'h0, 12'h000, 1'b0, 9'h1BF};

  logic [30:0] obs;
  assign obs = {estado, alusrc, alucontrol, immediate, negativo,
                branch, irwrite, pcwrite, pc_branch, regwrite,
                memread, memwrite, memtoreg, illegal};

  string       tag_q[$];
  logic [30:0] exp_q[$];
  logic [30:0] msk_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  function automatic logic [30:0] mk(input logic [3:0] st, input logic as, input logic [3:0] ac,
                                     input logic [11:0] im, input logic ng, input logic [8:0] sb);
    return {st, as, ac, im, ng, sb};
  endfunction

  task automatic push(input string t, input logic [30:0] e, input logic [30:0] m);
    tag_q.push_back(t);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic tick_check();
    string       t;
    logic [30:0] e, m;
    @(posedge clk);
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    compared++;
    assert ((obs & m) === (e & m)) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h (mask %h)", t, obs & m, e & m, m);
    end
  endtask

  task automatic drain();
    int n = exp_q.size();
    repeat (n) tick_check();
  endtask

  task automatic push_fetch(input string t);
    push({t, "_fetch"}, mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_CTRL);
  endtask

  task automatic run_alu(input string t, input logic [31:0] iw, input logic as, input logic [3:0] ac,
                         input logic [11:0] im, input logic ng, input logic rw, input logic [30:0] m);
    instr = iw;
    push({t, "_decode"}, mk(4'b0001, as, ac, im, ng, S_NONE), m);
    push({t, "_exec"},   mk(4'b0101, as, ac, im, ng, S_NONE), m);
    push({t, "_wb"},     mk(4'b1001, as, ac, im, ng, (rw ? S_RW : S_NONE) | S_PCW), m);
    push_fetch(t);
    drain();
  endtask

  task automatic run_branch(input string t, input logic [31:0] iw, input logic [3:0] ac,
                            input logic [11:0] im, input logic ng, input logic taken);
    instr = iw;
    pcsrc = taken;
    push({t, "_decode"},  mk(4'b0001, 1'b1, ac, im, ng, S_NONE), M_ALL);
    push({t, "_branch0"}, mk(4'b0110, 1'b1, ac, im, ng, S_BR), M_ALL);
    push({t, "_branch1"}, mk(4'b0110, 1'b1, ac, im, ng, S_BR), M_ALL);
    push({t, "_resolve"}, mk(4'b1011, 1'b1, ac, im, ng, (taken ? S_PCB : S_NONE) | S_PCW), M_ALL);
    push_fetch(t);
    drain();
  endtask

  logic [31:0] r_instr [5] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h0020D1B3};
  logic [3:0]  r_aluc  [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b0101};

  initial begin
    reset_n   = 1'b0;
    instr     = 32'h0;
    pcsrc     = 1'b0;
    mem_ready = 1'b1;

    push("reset0", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_NONE), M_ALL);
    push("reset1", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_NONE), M_ALL);
    drain();
    reset_n = 1'b1;
    push("reset_release", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_ALL);
    drain();

    run_alu("add", 32'h002081B3, 1'b0, 4'b0010, 12'h0, 1'b0, 1'b1, M_NOIMM);
    for (int i = 0; i < 5; i++)
      run_alu($sformatf("rop%0d", i), r_instr[i], 1'b0, r_aluc[i], 12'h0, 1'b0, 1'b1, M_NOIMM);
    run_alu("add_x0", 32'h00208033, 1'b0, 4'b0010, 12'h0, 1'b0, 1'b0, M_NOIMM);
    run_alu("addi_m5", 32'hFFB00093, 1'b1, 4'b0011, 12'd5, 1'b1, 1'b1, M_ALL);
    run_alu("addi_m2048", 32'h80000013, 1'b1, 4'b0011, 12'h800, 1'b1, 1'b0, M_ALL);

    instr = 32'h00812283;
    push("lw_decode", mk(4'b0001, 1'b1, 4'b0010, 12'd8, 1'b0, S_NONE), M_ALL);
    push("lw_exec",   mk(4'b0101, 1'b1, 4'b0010, 12'd8, 1'b0, S_NONE), M_ALL);
    push("lw_memrd",  mk(4'b0111, 1'b1, 4'b0010, 12'd8, 1'b0, S_MR), M_ALL);
    push("lw_wbmem",  mk(4'b1010, 1'b1, 4'b0010, 12'd8, 1'b0, S_RW | S_MTR | S_PCW), M_ALL);
    push_fetch("lw");
    drain();

    instr = 32'h00512223;
    push("sw_decode", mk(4'b0001, 1'b1, 4'b0010, 12'd4, 1'b0, S_NONE), M_ALL);
    push("sw_exec",   mk(4'b0101, 1'b1, 4'b0010, 12'd4, 1'b0, S_NONE), M_ALL);
    push("sw_memwr",  mk(4'b1000, 1'b1, 4'b0010, 12'd4, 1'b0, S_MW | S_PCW), M_ALL);
    push_fetch("sw");
    drain();

    run_branch("bne_taken", 32'hFE209CE3, 4'b1111, 12'd4, 1'b1, 1'b1);
    run_branch("beq_not", 32'h00108863, 4'b0110, 12'd8, 1'b0, 1'b0);
    pcsrc = 1'b0;

    instr = 32'h0000007F;
    push("illegal_op", mk(4'b0001, 1'b0, 4'h0, 12'h0, 1'b0, S_ILL), M_ILL);
    push_fetch("illegal_op");
    drain();
    instr = 32'h002091B3;
    push("illegal_f3", mk(4'b0001, 1'b0, 4'h0, 12'h0, 1'b0, S_ILL), M_ILL);
    push_fetch("illegal_f3");
    drain();

    instr = 32'h002081B3;
    push("abort_decode", mk(4'b0001, 1'b0, 4'b0010, 12'h0, 1'b0, S_NONE), M_NOIMM);
    push("abort_exec",   mk(4'b0101, 1'b0, 4'b0010, 12'h0, 1'b0, S_NONE), M_NOIMM);
    drain();
    reset_n = 1'b0;
    push("abort_reset", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_NONE), M_ALL);
    drain();
    reset_n = 1'b1;
    push("abort_release", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_ALL);
    drain();
    run_alu("after_abort", 32'hFFB00093, 1'b1, 4'b0011, 12'd5, 1'b1, 1'b1, M_ALL);

`ifdef MEM_WAIT_EN
    instr     = 32'h002081B3;
    mem_ready = 1'b0;
    push("wait_fetch0", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_CTRL);
    push("wait_fetch1", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_CTRL);
    push("wait_fetch2", mk(4'b0000, 1'b0, 4'h0, 12'h0, 1'b0, S_FETCH), M_CTRL);
    drain();
    mem_ready = 1'b1;
    run_alu("wait_add", 32'h002081B3, 1'b0, 4'b0010, 12'h0, 1'b0, 1'b1, M_NOIMM);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
